key_irq_ctrl: RTL

- CPU-side controller and sequencer for the POKEY keyboard scan path (KEY_core plus the keyboard clock from clock_gen_core).
- Decodes SKCTL, SKRES and IRQEN writes, and serves KBCODE, IRQST and SKSTAT reads.
- Holds the scanner in init until SKCTL enables it, then waits one full scan before exposing key status.
- Converts KEY_core event pulses into latched, maskable, active-low interrupts.

---
 rtl/key_irq_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/key_irq_ctrl.sv
// key_irq_ctrl: CPU register decode, scan sequencing and latched active-low IRQs for the POKEY keyboard path.
// Optional overrun tracking (SKSTAT bit 6, SKRES) is built only when KEY_OVERRUN_EN is defined.
module key_irq_ctrl #(
   parameter int WARMUP_CYC = 7296,
   parameter int CW         = 13
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enn,
   input  logic [3:0] addr,
   input  logic       wrEn,
   input  logic       rdEn,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       setKey,
   input  logic       setBreak,
   input  logic       keyDown,
   input  logic       kShift,
   input  logic [7:0] kbcodeIn,
   output logic [1:0] keyCtl,
   output logic       clkInit,
   output logic       irqN,
   output logic       statusValid
);
   typedef enum logic [1:0] {S_OFF, S_WARMUP, S_RUN} state_t;
   state_t r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [1:0] r_skctl, r_irqen, r_irqst, w_skctl_nxt, w_irqen_nxt, w_irqst_nxt;
   logic [7:0] r_kbcode, w_rd;
   logic r_keydown, r_kshift, r_irqn;
   logic w_run, w_wr_irqen, w_wr_skctl, w_key, w_brk, w_ovr, w_warm_done;
   assign w_run       = r_state == S_RUN;
   assign w_wr_irqen  = wrEn && addr == 4'hE;
   assign w_wr_skctl  = wrEn && addr == 4'hF;
   assign w_key       = w_run && setKey;
   assign w_brk       = w_run && setBreak;
   assign w_skctl_nxt = w_wr_skctl ? din[1:0] : r_skctl;
   assign w_irqen_nxt = w_wr_irqen ? din[7:6] : r_irqen;
   // A disabled source is held inactive, so a same-cycle mask write beats its event.
   assign w_irqst_nxt = {~w_irqen_nxt[1] | (r_irqst[1] & ~w_brk),
                         ~w_irqen_nxt[0] | (r_irqst[0] & ~w_key)};
   assign w_warm_done = enn && r_cnt == CW'(WARMUP_CYC - 1);
   assign irqN        = r_irqn;
`ifdef KEY_OVERRUN_EN
   logic r_ovr;
   logic w_wr_skres;
   assign w_wr_skres = wrEn && addr == 4'hA;
   assign w_ovr      = r_ovr;
   always_ff @(posedge clk) begin
      if (reset) r_ovr <= 1'b0;
      else if (w_key && !r_irqst[0]) r_ovr <= 1'b1;
      else if (w_wr_skres) r_ovr <= 1'b0;
   end
`else
   assign w_ovr = 1'b0;
`endif
   always_comb begin
      w_state_nxt = r_state;
      keyCtl      = 2'b00;
      clkInit     = 1'b1;
      statusValid = 1'b0;
      case (r_state)
         S_OFF: w_state_nxt = w_skctl_nxt != 2'b00 ? S_WARMUP : S_OFF;
         S_WARMUP: begin
            clkInit     = 1'b0;
            keyCtl      = r_skctl;
            w_state_nxt = w_warm_done ? S_RUN : S_WARMUP;
         end
         S_RUN: begin
            clkInit     = 1'b0;
            keyCtl      = r_skctl;
            statusValid = 1'b1;
         end
         default: w_state_nxt = S_OFF;
      endcase
      if (w_skctl_nxt == 2'b00) w_state_nxt = S_OFF;
   end
   always_comb
      w_rd = addr == 4'h9 ? r_kbcode :
             addr == 4'hE ? {r_irqst, 6'h3F} :
             addr == 4'hF ? {1'b1, ~w_ovr, 2'b11, ~(w_run & r_kshift), ~(w_run & r_keydown), 2'b11} :
             8'hFF;
   always_ff @(posedge clk) begin
      if (reset || r_state != S_WARMUP) r_cnt <= '0;
      else if (enn) r_cnt <= r_cnt + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_OFF;
         r_skctl   <= 2'b00;
         r_irqen   <= 2'b00;
         r_irqst   <= 2'b11;
         r_irqn    <= 1'b1;
         r_kbcode  <= 8'hFF;
         r_keydown <= 1'b0;
         r_kshift  <= 1'b0;
         dout      <= 8'hFF;
      end else begin
         r_state   <= w_state_nxt;
         r_skctl   <= w_skctl_nxt;
         r_irqen   <= w_irqen_nxt;
         r_irqst   <= w_irqst_nxt;
         r_irqn    <= &r_irqst;
         r_keydown <= w_run & keyDown;
         r_kshift  <= w_run & kShift;
         if (w_key) r_kbcode <= kbcodeIn;
         if (rdEn) dout <= w_rd;
      end
   end
endmodule
